// File: rtl/seg_decode_monitor.sv
// Seven-segment bus reader: filters the sampled pattern for stability, decodes it to a value
// (0..19, blank or illegal) and keeps saturating acceptance / illegal-pattern counters.
module seg_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_BITS      = 8
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [7:0]          seg_in,
  input  logic                clear,
  output logic [4:0]          value,
  output logic                dp,
  output logic                blank,
  output logic                err,
  output logic                locked,
  output logic                value_stb,
  output logic [CNT_BITS-1:0] accept_cnt,
  output logic [CNT_BITS-1:0] err_cnt
);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] value;
    logic       blank;
    logic       err;
  } dec_t;

  // dp adds ten to a legal digit; blank and illegal patterns ignore it for the value.
  function automatic dec_t decode_seg(input logic [6:0] segs, input logic dp_bit);
    dec_t       d;
    logic [4:0] digit;
    logic       is_blank;
    logic       is_err;
    digit    = 5'd0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (segs)
      7'h3F:   digit = 5'd0;
      7'h06:   digit = 5'd1;
      7'h5B:   digit = 5'd2;
      7'h4F:   digit = 5'd3;
      7'h66:   digit = 5'd4;
      7'h6D:   digit = 5'd5;
      7'h7D:   digit = 5'd6;
      7'h07:   digit = 5'd7;
      7'h7F:   digit = 5'd8;
      7'h6F:   digit = 5'd9;
      7'h00:   is_blank = 1'b1;
      default: is_err = 1'b1;
    endcase
    d.blank = is_blank;
    d.err   = is_err;
    if (is_err) begin
      d.value = 5'd31;
    end else if (is_blank) begin
      d.value = 5'd0;
    end else begin
      d.value = digit + (dp_bit ? 5'd10 : 5'd0);
    end
    return d;
  endfunction

  logic [7:0]          seg_q;
  logic [7:0]          cand_q, cand_d;
  logic [7:0]          stab_q, stab_d;
  state_t              state_q, state_d;
  logic                accept_d;
  logic [8:0]          stab_inc_s;
  dec_t                dec_s;
  logic [4:0]          value_q;
  logic                dp_q, blank_q, err_q, stb_q;
  logic [CNT_BITS-1:0] accept_cnt_q, accept_cnt_d;
  logic [CNT_BITS-1:0] err_cnt_q, err_cnt_d;

  // Stability filter, decode and counter next-state.
  always_comb begin
    cand_d       = cand_q;
    stab_d       = stab_q;
    state_d      = state_q;
    accept_d     = 1'b0;
    stab_inc_s   = {1'b0, stab_q} + 9'd1;
    dec_s        = decode_seg(seg_q[6:0], seg_q[7]);
    accept_cnt_d = accept_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (seg_q != cand_q) begin
      cand_d = seg_q;
      stab_d = 8'd1;
      if (STABLE_CYCLES == 32'd1) begin
        state_d  = LOCKED;
        accept_d = 1'b1;
      end else begin
        state_d = SETTLE;
      end
    end else if (state_q == SETTLE) begin
      stab_d = stab_inc_s[7:0];
      if (stab_inc_s == 9'(STABLE_CYCLES)) begin
        state_d  = LOCKED;
        accept_d = 1'b1;
      end else begin
        state_d = SETTLE;
      end
    end else begin
      state_d = LOCKED;
    end

    // clear overrides a coincident acceptance.
    if (clear) begin
      accept_cnt_d = '0;
      err_cnt_d    = '0;
    end else if (accept_d) begin
      if (accept_cnt_q != '1) begin
        accept_cnt_d = accept_cnt_q + CNT_BITS'(1);
      end else begin
        accept_cnt_d = accept_cnt_q;
      end
      if (dec_s.err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_BITS'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      accept_cnt_d = accept_cnt_q;
      err_cnt_d    = err_cnt_q;
    end
  end

  // Input sampling, FSM state and registered outputs.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      seg_q        <= 8'h00;
      cand_q       <= 8'h00;
      stab_q       <= 8'd0;
      state_q      <= SETTLE;
      value_q      <= 5'd0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b0;
      err_q        <= 1'b0;
      stb_q        <= 1'b0;
      accept_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      seg_q        <= seg_in;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      state_q      <= state_d;
      stb_q        <= accept_d;
      accept_cnt_q <= accept_cnt_d;
      err_cnt_q    <= err_cnt_d;
      if (accept_d) begin
        value_q <= dec_s.value;
        dp_q    <= seg_q[7];
        blank_q <= dec_s.blank;
        err_q   <= dec_s.err;
      end else begin
        value_q <= value_q;
        dp_q    <= dp_q;
        blank_q <= blank_q;
        err_q   <= err_q;
      end
    end
  end

  assign value      = value_q;
  assign dp         = dp_q;
  assign blank      = blank_q;
  assign err        = err_q;
  assign locked     = (state_q == LOCKED);
  assign value_stb  = stb_q;
  assign accept_cnt = accept_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Bench for seg_decode_monitor: instance A uses defaults, instance B uses STABLE_CYCLES=1, CNT_BITS=2.
module tb_seg_decode_monitor;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       clear_b = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic [7:0] seg_in_b = 8'h00;

  logic [4:0] value, value_b;
  logic       dp, blank, err, locked, value_stb;
  logic       dp_b, blank_b, err_b, locked_b, value_stb_b;
  logic [7:0] accept_cnt, err_cnt;
  logic [1:0] accept_cnt_b, err_cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] v;
    logic       dp;
    logic       blank;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  seg_decode_monitor dut_a (
    .clk_2(clk_2), .reset(reset), .seg_in(seg_in), .clear(clear),
    .value(value), .dp(dp), .blank(blank), .err(err), .locked(locked),
    .value_stb(value_stb), .accept_cnt(accept_cnt), .err_cnt(err_cnt)
  );

  seg_decode_monitor #(.STABLE_CYCLES(1), .CNT_BITS(2)) dut_b (
    .clk_2(clk_2), .reset(reset), .seg_in(seg_in_b), .clear(clear_b),
    .value(value_b), .dp(dp_b), .blank(blank_b), .err(err_b), .locked(locked_b),
    .value_stb(value_stb_b), .accept_cnt(accept_cnt_b), .err_cnt(err_cnt_b)
  );

  always #5 clk_2 = ~clk_2;

  // Every acceptance pulse on instance A must match the oldest queued expectation.
  always @(negedge clk_2) begin
    if (value_stb === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pulse: got value=%0d dp=%0b blank=%0b err=%0b, expected no acceptance",
                 value, dp, blank, err);
      end else begin
        sb_e = exp_q.pop_front();
        if ({value, dp, blank, err} !== sb_e) begin
          errors++;
          $display("FAIL sb_accept: got value=%0d dp=%0b blank=%0b err=%0b expected value=%0d dp=%0b blank=%0b err=%0b",
                   value, dp, blank, err, sb_e.v, sb_e.dp, sb_e.blank, sb_e.err);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  task automatic test_reset;
    seg_in = 8'h06;
    reset  = 1'b1;
    step(2);
    checks++;
    if ({value, dp, blank, err, locked, value_stb, accept_cnt, err_cnt} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {value, dp, blank, err, locked, value_stb, accept_cnt, err_cnt});
    end
    exp_q.push_back(exp_t'({5'd1, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;
  endtask

  task automatic test_first_accept;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      checks++;
      if (value_stb !== (e == 5)) begin
        errors++;
        $display("FAIL t1_stb edge=%0d: got %0b expected %0b", e, value_stb, (e == 5));
      end
      checks++;
      if (locked !== (e == 5)) begin
        errors++;
        $display("FAIL t1_locked edge=%0d: got %0b expected %0b", e, locked, (e == 5));
      end
    end
    checks++;
    if ({value, err, accept_cnt} !== {5'd1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL t1_state: got value=%0d err=%0b acc=%0d expected 1 0 1", value, err, accept_cnt);
    end
    step(1);
    checks++;
    if (value_stb !== 1'b0) begin
      errors++;
      $display("FAIL t1_single_pulse: got %0b expected 0", value_stb);
    end
  endtask

  task automatic test_dp_digit;
    seg_in = 8'hDB;
    exp_q.push_back(exp_t'({5'd12, 1'b1, 1'b0, 1'b0}));
    for (int e = 1; e <= 5; e++) begin
      step(1);
      checks++;
      if (value_stb !== (e == 5)) begin
        errors++;
        $display("FAIL t2_stb edge=%0d: got %0b expected %0b", e, value_stb, (e == 5));
      end
      if (e >= 2 && e <= 4) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL t2_settle_locked edge=%0d: got %0b expected 0", e, locked);
        end
      end
    end
    checks++;
    if ({value, dp, blank, accept_cnt} !== {5'd12, 1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL t2_state: got value=%0d dp=%0b blank=%0b acc=%0d expected 12 1 0 2",
               value, dp, blank, accept_cnt);
    end
  endtask

  task automatic test_glitch;
    seg_in = 8'h4F;
    exp_q.push_back(exp_t'({5'd3, 1'b0, 1'b0, 1'b0}));
    step(5);
    checks++;
    if ({value, locked, accept_cnt} !== {5'd3, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL t3_lock: got value=%0d locked=%0b acc=%0d expected 3 1 3", value, locked, accept_cnt);
    end
    seg_in = 8'h7F;
    step(2);
    checks++;
    if ({locked, value} !== {1'b0, 5'd3}) begin
      errors++;
      $display("FAIL t3_glitch: got locked=%0b value=%0d expected 0 3", locked, value);
    end
    seg_in = 8'h4F;
    exp_q.push_back(exp_t'({5'd3, 1'b0, 1'b0, 1'b0}));
    for (int e = 1; e <= 5; e++) begin
      step(1);
      checks++;
      if ({value_stb, locked, value} !== {(e == 5), (e == 5), 5'd3}) begin
        errors++;
        $display("FAIL t3_resettle edge=%0d: got stb=%0b locked=%0b value=%0d expected %0b %0b 3",
                 e, value_stb, locked, value, (e == 5), (e == 5));
      end
    end
    checks++;
    if (accept_cnt !== 8'd4) begin
      errors++;
      $display("FAIL t3_acc: got %0d expected 4", accept_cnt);
    end
  endtask

  task automatic test_illegal;
    seg_in = 8'h49;
    exp_q.push_back(exp_t'({5'd31, 1'b0, 1'b0, 1'b1}));
    step(5);
    checks++;
    if ({err, value, blank, err_cnt, accept_cnt} !== {1'b1, 5'd31, 1'b0, 8'd1, 8'd5}) begin
      errors++;
      $display("FAIL t4_illegal: got err=%0b value=%0d blank=%0b errc=%0d acc=%0d expected 1 31 0 1 5",
               err, value, blank, err_cnt, accept_cnt);
    end
    seg_in = 8'h3F;
    exp_q.push_back(exp_t'({5'd0, 1'b0, 1'b0, 1'b0}));
    step(5);
    checks++;
    if ({err, value, err_cnt, accept_cnt} !== {1'b0, 5'd0, 8'd1, 8'd6}) begin
      errors++;
      $display("FAIL t4_legal_after: got err=%0b value=%0d errc=%0d acc=%0d expected 0 0 1 6",
               err, value, err_cnt, accept_cnt);
    end
  endtask

  task automatic test_saturate_clear;
    logic [1:0] acc_m;
    logic [1:0] errc_m;
    acc_m   = 2'd0;
    errc_m  = 2'd0;
    clear_b = 1'b1;
    step(1);
    clear_b = 1'b0;
    checks++;
    if ({accept_cnt_b, err_cnt_b} !== 4'd0) begin
      errors++;
      $display("FAIL t5_clear_init: got acc=%0d errc=%0d expected 0 0", accept_cnt_b, err_cnt_b);
    end
    for (int i = 0; i < 5; i++) begin
      seg_in_b = (i % 2 == 0) ? 8'h06 : 8'h49;
      step(1);
      checks++;
      if (value_stb_b !== 1'b0) begin
        errors++;
        $display("FAIL t5_early_stb i=%0d: got %0b expected 0", i, value_stb_b);
      end
      step(1);
      if (acc_m != 2'd3) acc_m = acc_m + 2'd1;
      if (i % 2 == 1 && errc_m != 2'd3) errc_m = errc_m + 2'd1;
      checks++;
      if ({value_stb_b, accept_cnt_b, err_cnt_b} !== {1'b1, acc_m, errc_m}) begin
        errors++;
        $display("FAIL t5_count i=%0d: got stb=%0b acc=%0d errc=%0d expected 1 %0d %0d",
                 i, value_stb_b, accept_cnt_b, err_cnt_b, acc_m, errc_m);
      end
    end
    checks++;
    if (value_b !== 5'd1) begin
      errors++;
      $display("FAIL t5_sc1_value: got %0d expected 1", value_b);
    end
    seg_in_b = 8'h49;
    step(1);
    clear_b = 1'b1;
    step(1);
    clear_b = 1'b0;
    checks++;
    if ({value_stb_b, err_b, accept_cnt_b, err_cnt_b} !== {1'b1, 1'b1, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL t5_clear_wins: got stb=%0b err=%0b acc=%0d errc=%0d expected 1 1 0 0",
               value_stb_b, err_b, accept_cnt_b, err_cnt_b);
    end
    step(1);
    checks++;
    if (value_stb_b !== 1'b0) begin
      errors++;
      $display("FAIL t5_pulse_len: got %0b expected 0", value_stb_b);
    end
  endtask

  task automatic test_blank_and_reset;
    reset  = 1'b1;
    seg_in = 8'h00;
    step(1);
    exp_q.push_back(exp_t'({5'd0, 1'b0, 1'b1, 1'b0}));
    reset = 1'b0;
    step(5);
    checks++;
    if ({blank, value, err, locked} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL t6_blank: got blank=%0b value=%0d err=%0b locked=%0b expected 1 0 0 1",
               blank, value, err, locked);
    end
    seg_in = 8'h80;
    exp_q.push_back(exp_t'({5'd0, 1'b1, 1'b1, 1'b0}));
    step(5);
    checks++;
    if ({blank, dp, value} !== {1'b1, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL t6_blank_dp: got blank=%0b dp=%0b value=%0d expected 1 1 0", blank, dp, value);
    end
    seg_in = 8'h66;
    step(2);
    reset = 1'b1;
    #1;
    checks++;
    if ({value, dp, blank, err, locked, value_stb, accept_cnt, err_cnt} !== 26'd0) begin
      errors++;
      $display("FAIL t6_async_reset: got %h expected 0",
               {value, dp, blank, err, locked, value_stb, accept_cnt, err_cnt});
    end
    step(1);
    exp_q.push_back(exp_t'({5'd4, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      checks++;
      if (value_stb !== (e == 5)) begin
        errors++;
        $display("FAIL t6_resettle edge=%0d: got %0b expected %0b", e, value_stb, (e == 5));
      end
    end
    checks++;
    if (accept_cnt !== 8'd1) begin
      errors++;
      $display("FAIL t6_acc_after_reset: got %0d expected 1", accept_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_dp_digit();
    test_glitch();
    test_illegal();
    test_saturate_clear();
    test_blank_and_reset();
    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_pending: got %0d unmatched expectations expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
